// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 32-bit datapath.
// Steps through fetch (T0-T2) and per-opcode execute steps (T3-T7),
// driving the datapath's one-bit control strobes as a Moore decode of the
// registered state {phase, step, waitcnt, op_r}.
// Optional feature macro: SINGLE_STEP_EN adds a step_req input that gates
// step/waitcnt advancement while running.
// The phase output exposes the FSM state: 0=IDLE, 1=RUN, 2=HALT.
module control_sequencer #(
  parameter int OPW      = 5,
  parameter int MEM_WAIT = 1,
  parameter int STEPS    = 8,
  localparam int SW      = $clog2(STEPS)
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic           run,
`ifdef SINGLE_STEP_EN
  input  logic           step_req,
`endif
  input  logic [OPW-1:0] opcode,
  output logic [SW-1:0]  step,
  output logic [1:0]     phase,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           PCin,
  output logic           Read,
  output logic           Write,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           HIin,
  output logic           LOin,
  output logic           CONin,
  output logic           Outportin,
  output logic           Inportout,
  output logic           halted,
  output logic           illegal
);

  typedef enum logic [1:0] {P_IDLE = 2'd0, P_RUN = 2'd1, P_HALT = 2'd2} phase_t;

  localparam logic [SW-1:0] T0 = SW'(0);
  localparam logic [SW-1:0] T1 = SW'(1);
  localparam logic [SW-1:0] T2 = SW'(2);
  localparam logic [SW-1:0] T3 = SW'(3);
  localparam logic [SW-1:0] T4 = SW'(4);
  localparam logic [SW-1:0] T5 = SW'(5);
  localparam logic [SW-1:0] T6 = SW'(6);
  localparam logic [SW-1:0] T7 = SW'(7);
  localparam logic [2:0]    MW = 3'(MEM_WAIT);

  localparam logic [OPW-1:0] OP_LD     = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_ST     = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ALU_LO = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ALU_HI = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_MUL    = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV    = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_IN     = OPW'(5'b10101);
  localparam logic [OPW-1:0] OP_OUT    = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_NOP    = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT   = OPW'(5'b11011);

  phase_t         phase_r, phase_n;
  logic [SW-1:0]  step_r, step_n;
  logic [2:0]     wait_r, wait_n;
  logic [OPW-1:0] op_r, op_n;
  logic           illegal_r, illegal_n;
  logic           adv;

  logic is_alu, is_md, is_ld, is_st, is_in, is_out, is_nop, is_halt, legal;
  logic mem_step, last_step;

`ifdef SINGLE_STEP_EN
  assign adv = step_req;
`else
  assign adv = 1'b1;
`endif

  assign step    = step_r;
  assign phase   = phase_r;
  assign halted  = (phase_r == P_HALT);
  assign illegal = illegal_r;

  // Classify the latched opcode and find memory-hold and final steps
  always_comb begin
    is_alu    = (op_r >= OP_ALU_LO) && (op_r <= OP_ALU_HI);
    is_md     = (op_r == OP_MUL) || (op_r == OP_DIV);
    is_ld     = (op_r == OP_LD);
    is_st     = (op_r == OP_ST);
    is_in     = (op_r == OP_IN);
    is_out    = (op_r == OP_OUT);
    is_nop    = (op_r == OP_NOP);
    is_halt   = (op_r == OP_HALT);
    legal     = is_alu | is_md | is_ld | is_st | is_in | is_out | is_nop | is_halt;
    mem_step  = (step_r == T1) || (step_r == T6 && is_ld) || (step_r == T7 && is_st);
    last_step = (step_r == T3 && (is_in | is_out | is_nop)) ||
                (step_r == T5 && is_alu) ||
                (step_r == T6 && is_md) ||
                (step_r == T7 && (is_ld | is_st));
  end

  // State register with synchronous active-low clear
  always_ff @(posedge Clock) begin
    if (!clear) begin
      phase_r   <= P_IDLE;
      step_r    <= T0;
      wait_r    <= 3'd0;
      op_r      <= '0;
      illegal_r <= 1'b0;
    end else begin
      phase_r   <= phase_n;
      step_r    <= step_n;
      wait_r    <= wait_n;
      op_r      <= op_n;
      illegal_r <= illegal_n;
    end
  end

  // Next-state: phase transitions, memory wait counting, step sequencing
  always_comb begin
    phase_n   = phase_r;
    step_n    = step_r;
    wait_n    = wait_r;
    op_n      = op_r;
    illegal_n = illegal_r;
    case (phase_r)
      P_IDLE: begin
        if (run) begin
          phase_n = P_RUN;
          step_n  = T0;
          wait_n  = 3'd0;
        end
      end
      P_RUN: begin
        // halt and undecoded opcodes trap straight out of T3
        if (step_r == T3 && (is_halt || !legal)) begin
          phase_n = P_HALT;
          step_n  = T0;
          wait_n  = 3'd0;
          if (!legal) illegal_n = 1'b1;
        end else if (adv) begin
          if (mem_step && wait_r != MW) begin
            wait_n = wait_r + 3'd1;
          end else begin
            wait_n = 3'd0;
            if (last_step) begin
              step_n  = T0;
              phase_n = run ? P_RUN : P_IDLE;
            end else begin
              step_n = step_r + SW'(1);
              if (step_r == T2) op_n = opcode;
            end
          end
        end
      end
      P_HALT: begin
        phase_n = P_HALT;
      end
      default: begin
        phase_n = P_IDLE;
        step_n  = T0;
        wait_n  = 3'd0;
      end
    endcase
  end

  // Moore strobe decode from phase, step and latched opcode
  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0; Read = 1'b0;
    Write = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0; CONin = 1'b0;
    Outportin = 1'b0; Inportout = 1'b0;
    if (phase_r == P_RUN) begin
      case (step_r)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        T3: begin
          if (is_alu)              begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          if (is_md)               begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          if (is_ld | is_st)       begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          if (is_out)              begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
          if (is_in)               begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        end
        T4: begin
          if (is_alu)              begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          if (is_md)               begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          if (is_ld | is_st)       begin Cout = 1'b1; Zin = 1'b1; end
        end
        T5: begin
          if (is_alu)              begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          if (is_md)               begin Zlowout = 1'b1; LOin = 1'b1; end
          if (is_ld | is_st)       begin Zlowout = 1'b1; MARin = 1'b1; end
        end
        T6: begin
          if (is_md)               begin Zhighout = 1'b1; HIin = 1'b1; end
          if (is_ld)               begin Read = 1'b1; MDRin = 1'b1; end
          if (is_st)               begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        end
        T7: begin
          if (is_ld)               begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          if (is_st)               begin MDRout = 1'b1; Write = 1'b1; end
        end
        default: begin end
      endcase
    end
  end

endmodule
